// File: rtl/exu_wb.sv
// exu_wb: execute-unit writeback stage.
// Merges ALU results and out-of-band load responses into one registered GPR
// write per cycle. Tracks outstanding load destinations for RAW/WAW stalls
// and reports idle for fence/flush logic.
module exu_wb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned GPR_AW = 5,
  parameter int unsigned MAX_LD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_vld,
  output logic              alu_rdy,
  input  logic [GPR_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_iss_vld,
  output logic              ld_iss_rdy,
  input  logic [GPR_AW-1:0] ld_iss_rd,
  input  logic              ld_rsp_vld,
  input  logic [GPR_AW-1:0] ld_rsp_rd,
  input  logic [XLEN-1:0]   ld_rsp_data,
  input  logic [GPR_AW-1:0] hz_rs1,
  input  logic [GPR_AW-1:0] hz_rs2,
  input  logic [GPR_AW-1:0] hz_rd,
  output logic              hz_stall,
  output logic              gpr_w_wen,
  output logic [GPR_AW-1:0] gpr_w_addr,
  output logic [XLEN-1:0]   gpr_w_data,
  output logic              idle,
  output logic              err
);

  localparam int unsigned NREG  = 1 << GPR_AW;
  localparam int unsigned CNT_W = 3;

  // Skid entry holding an ALU result displaced by a load response
  logic              skid_vld;
  logic [GPR_AW-1:0] skid_rd;
  logic [XLEN-1:0]   skid_data;

  // Scoreboard of destinations with a load in flight, plus load count
  logic [NREG-1:0]   pend;
  logic [CNT_W-1:0]  ld_cnt;

  // Next-state signals
  logic              alu_hs;
  logic              iss_hs;
  logic              win_vld;
  logic [GPR_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  logic              skid_load;
  logic              skid_pop;
  logic [NREG-1:0]   pend_nxt;
  logic [CNT_W-1:0]  ld_cnt_nxt;
  logic              err_nxt;

  // A register is busy if a load targets it, the skid holds it, or the
  // registered write has not yet reached the GPR file.
  function automatic logic reg_busy(
    input logic [GPR_AW-1:0] r,
    input logic [NREG-1:0]   pnd,
    input logic              s_vld,
    input logic [GPR_AW-1:0] s_rd,
    input logic              w_en,
    input logic [GPR_AW-1:0] w_addr
  );
    logic busy;
    busy = pnd[r] | (s_vld & (s_rd == r)) | (w_en & (w_addr == r));
    return (r != '0) & busy;
  endfunction

  // Handshake and ready signals
  always_comb begin
    alu_rdy    = !skid_vld;
    ld_iss_rdy = (ld_cnt < CNT_W'(MAX_LD)) & !pend[ld_iss_rd];
    alu_hs     = alu_vld & alu_rdy;
    iss_hs     = ld_iss_vld & ld_iss_rdy;
  end

  // Write-source arbitration: load response > skid > ALU input
  always_comb begin
    win_vld   = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    skid_load = 1'b0;
    skid_pop  = 1'b0;
    if (ld_rsp_vld) begin
      win_vld   = 1'b1;
      win_rd    = ld_rsp_rd;
      win_data  = ld_rsp_data;
      skid_load = alu_hs;
    end else if (skid_vld) begin
      win_vld  = 1'b1;
      win_rd   = skid_rd;
      win_data = skid_data;
      skid_pop = 1'b1;
    end else if (alu_hs) begin
      win_vld  = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end
  end

  // Scoreboard, load counter and protocol-error next state
  always_comb begin
    pend_nxt   = pend;
    ld_cnt_nxt = ld_cnt;
    err_nxt    = err;
    if (ld_rsp_vld) begin
      pend_nxt[ld_rsp_rd] = 1'b0;
    end
    // Set after clear so a same-cycle issue to the same rd wins
    if (iss_hs && (ld_iss_rd != '0)) begin
      pend_nxt[ld_iss_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
    if (ld_rsp_vld && (ld_cnt == '0)) begin
      err_nxt = 1'b1;
    end
    if (iss_hs && !ld_rsp_vld) begin
      ld_cnt_nxt = ld_cnt + CNT_W'(1);
    end else if (!iss_hs && ld_rsp_vld && (ld_cnt != '0)) begin
      ld_cnt_nxt = ld_cnt - CNT_W'(1);
    end
  end

  // Hazard stall and idle reporting
  always_comb begin
    hz_stall = reg_busy(hz_rs1, pend, skid_vld, skid_rd, gpr_w_wen, gpr_w_addr)
             | reg_busy(hz_rs2, pend, skid_vld, skid_rd, gpr_w_wen, gpr_w_addr)
             | reg_busy(hz_rd,  pend, skid_vld, skid_rd, gpr_w_wen, gpr_w_addr);
    idle     = (ld_cnt == '0) & !skid_vld & !gpr_w_wen;
  end

  // Registered GPR write port; rd=0 winners are consumed without a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_w_wen  <= 1'b0;
      gpr_w_addr <= '0;
      gpr_w_data <= '0;
    end else begin
      gpr_w_wen <= win_vld & (win_rd != '0);
      if (win_vld && (win_rd != '0)) begin
        gpr_w_addr <= win_rd;
        gpr_w_data <= win_data;
      end
    end
  end

  // Skid entry: fills on ALU/response collision, drains on a free cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld  <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_vld  <= 1'b1;
      skid_rd   <= alu_rd;
      skid_data <= alu_data;
    end else if (skid_pop) begin
      skid_vld  <= 1'b0;
    end
  end

  // Scoreboard, load counter and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      ld_cnt <= '0;
      err    <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      ld_cnt <= ld_cnt_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_exu_wb.sv
// tb_exu_wb: directed and randomized checks of exu_wb against a queue-based
// reference model of the writeback rules.
module tb_exu_wb;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned GPR_AW = 5;
  localparam int unsigned MAX_LD = 2;

  logic              clk;
  logic              rst;
  logic              alu_vld;
  logic              alu_rdy;
  logic [GPR_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_iss_vld;
  logic              ld_iss_rdy;
  logic [GPR_AW-1:0] ld_iss_rd;
  logic              ld_rsp_vld;
  logic [GPR_AW-1:0] ld_rsp_rd;
  logic [XLEN-1:0]   ld_rsp_data;
  logic [GPR_AW-1:0] hz_rs1;
  logic [GPR_AW-1:0] hz_rs2;
  logic [GPR_AW-1:0] hz_rd;
  logic              hz_stall;
  logic              gpr_w_wen;
  logic [GPR_AW-1:0] gpr_w_addr;
  logic [XLEN-1:0]   gpr_w_data;
  logic              idle;
  logic              err;

  int tests = 0;
  int fails = 0;

  exu_wb #(.XLEN(XLEN), .GPR_AW(GPR_AW), .MAX_LD(MAX_LD)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_vld     (alu_vld),
    .alu_rdy     (alu_rdy),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_iss_vld  (ld_iss_vld),
    .ld_iss_rdy  (ld_iss_rdy),
    .ld_iss_rd   (ld_iss_rd),
    .ld_rsp_vld  (ld_rsp_vld),
    .ld_rsp_rd   (ld_rsp_rd),
    .ld_rsp_data (ld_rsp_data),
    .hz_rs1      (hz_rs1),
    .hz_rs2      (hz_rs2),
    .hz_rd       (hz_rd),
    .hz_stall    (hz_stall),
    .gpr_w_wen   (gpr_w_wen),
    .gpr_w_addr  (gpr_w_addr),
    .gpr_w_data  (gpr_w_data),
    .idle        (idle),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_pend [32];
  int          m_cnt;
  logic [4:0]  q_rd [$];
  logic [31:0] q_data [$];
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    q_rd.delete();
    q_data.delete();
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_pend[r]) return 1'b1;
    if (q_rd.size() != 0 && q_rd[0] == r) return 1'b1;
    if (m_wen && m_addr == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
    ld_iss_vld = 1'b0; ld_iss_rd = '0;
    ld_rsp_vld = 1'b0; ld_rsp_rd = '0; ld_rsp_data = '0;
    hz_rs1 = '0; hz_rs2 = '0; hz_rd = '0;
  endtask

  // One clock cycle: check combinational outputs, advance model, check write port
  task automatic cyc();
    bit          e_iss_rdy;
    bit          alu_take;
    bit          iss_take;
    bit          w_vld;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    #1;
    e_iss_rdy = (m_cnt < int'(MAX_LD)) && !m_pend[ld_iss_rd];
    chk("alu_rdy", 64'(alu_rdy), 64'(q_rd.size() == 0));
    chk("ld_iss_rdy", 64'(ld_iss_rdy), 64'(e_iss_rdy));
    chk("hz_stall", 64'(hz_stall), 64'(m_busy(hz_rs1) || m_busy(hz_rs2) || m_busy(hz_rd)));
    chk("idle", 64'(idle), 64'(m_cnt == 0 && q_rd.size() == 0 && !m_wen));
    alu_take = alu_vld && (q_rd.size() == 0);
    iss_take = ld_iss_vld && e_iss_rdy;
    w_vld = 1'b0; w_rd = '0; w_data = '0;
    if (ld_rsp_vld) begin
      w_vld = 1'b1; w_rd = ld_rsp_rd; w_data = ld_rsp_data;
      if (alu_take) begin
        q_rd.push_back(alu_rd);
        q_data.push_back(alu_data);
      end
    end else if (q_rd.size() != 0) begin
      w_vld = 1'b1; w_rd = q_rd.pop_front(); w_data = q_data.pop_front();
    end else if (alu_take) begin
      w_vld = 1'b1; w_rd = alu_rd; w_data = alu_data;
    end
    m_wen = w_vld && (w_rd != 5'd0);
    if (m_wen) begin
      m_addr = w_rd;
      m_data = w_data;
    end
    if (ld_rsp_vld) begin
      if (m_cnt == 0) m_err = 1'b1;
      m_pend[ld_rsp_rd] = 1'b0;
    end
    if (iss_take && ld_iss_rd != 5'd0) m_pend[ld_iss_rd] = 1'b1;
    if (iss_take && !ld_rsp_vld) m_cnt++;
    else if (!iss_take && ld_rsp_vld && m_cnt > 0) m_cnt--;
    @(posedge clk);
    @(negedge clk);
    chk("gpr_w_wen", 64'(gpr_w_wen), 64'(m_wen));
    chk("err", 64'(err), 64'(m_err));
    if (m_wen) begin
      chk("gpr_w_addr", 64'(gpr_w_addr), 64'(m_addr));
      chk("gpr_w_data", 64'(gpr_w_data), 64'(m_data));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"},  64'(gpr_w_wen),  64'(0));
    chk({tag, "_addr"}, 64'(gpr_w_addr), 64'(0));
    chk({tag, "_data"}, 64'(gpr_w_data), 64'(0));
    chk({tag, "_err"},  64'(err),        64'(0));
    chk({tag, "_alu_rdy"}, 64'(alu_rdy),    64'(1));
    chk({tag, "_iss_rdy"}, 64'(ld_iss_rdy), 64'(1));
    chk({tag, "_stall"},   64'(hz_stall),   64'(0));
    chk({tag, "_idle"},    64'(idle),       64'(1));
  endtask

  // Bound on total run time
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] plist [$];
    rst = 1'b1;
    set_idle();
    model_reset();
    #12;
    chk_reset_vals("rst_during");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_after");

    // ALU stream x1..x4
    for (int i = 1; i <= 4; i++) begin
      alu_vld = 1'b1; alu_rd = 5'(i); alu_data = 32'(32'h10 + i - 1);
      cyc();
      chk("stream_addr", 64'(gpr_w_addr), 64'(i));
      chk("stream_data", 64'(gpr_w_data), 64'(32'h10 + i - 1));
      chk("stream_alu_rdy", 64'(alu_rdy), 64'(1));
    end

    // Collision of ALU result with a load response
    set_idle(); ld_iss_vld = 1'b1; ld_iss_rd = 5'd6;
    cyc();
    set_idle();
    alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'hAA;
    ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd6; ld_rsp_data = 32'hBB;
    cyc();
    chk("col_first_addr", 64'(gpr_w_addr), 64'(6));
    chk("col_first_data", 64'(gpr_w_data), 64'(32'hBB));
    set_idle();
    #1 chk("col_alu_rdy_low", 64'(alu_rdy), 64'(0));
    cyc();
    chk("col_second_addr", 64'(gpr_w_addr), 64'(5));
    chk("col_second_data", 64'(gpr_w_data), 64'(32'hAA));

    // Scoreboard stall on x7
    set_idle(); ld_iss_vld = 1'b1; ld_iss_rd = 5'd7; hz_rs1 = 5'd7;
    cyc();
    ld_iss_vld = 1'b0;
    #1 chk("sb_stall_pend", 64'(hz_stall), 64'(1));
    cyc();
    ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd7; ld_rsp_data = 32'h77;
    #1 chk("sb_stall_rsp", 64'(hz_stall), 64'(1));
    cyc();
    ld_rsp_vld = 1'b0;
    #1 chk("sb_stall_wen", 64'(hz_stall), 64'(1));
    cyc();
    #1 chk("sb_stall_clear", 64'(hz_stall), 64'(0));

    // Capacity limit and per-rd exclusivity
    set_idle(); ld_iss_vld = 1'b1; ld_iss_rd = 5'd8;
    cyc();
    ld_iss_rd = 5'd9;
    cyc();
    ld_iss_rd = 5'd10;
    #1 chk("cap_full", 64'(ld_iss_rdy), 64'(0));
    cyc();
    set_idle(); ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd9; ld_rsp_data = 32'h99;
    cyc();
    set_idle(); ld_iss_vld = 1'b1; ld_iss_rd = 5'd8;
    #1 chk("cap_pending_rd", 64'(ld_iss_rdy), 64'(0));
    cyc();
    set_idle(); ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd8; ld_rsp_data = 32'h88;
    cyc();
    set_idle();
    cyc();

    // ALU write to x0 is consumed silently
    alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    cyc();
    chk("x0_wen", 64'(gpr_w_wen), 64'(0));

    // Issue and response to x3 in one cycle: set wins, count unchanged
    set_idle(); ld_iss_vld = 1'b1; ld_iss_rd = 5'd11;
    cyc();
    ld_iss_rd = 5'd3;
    ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd3; ld_rsp_data = 32'h33;
    cyc();
    set_idle(); hz_rs1 = 5'd3;
    cyc();
    ld_iss_rd = 5'd20;
    #1 chk("same_pend3", 64'(hz_stall), 64'(1));
    chk("same_cnt_one", 64'(ld_iss_rdy), 64'(1));
    set_idle(); ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd11; ld_rsp_data = 32'h11;
    cyc();

    // Response with no load counted: sticky error, data still written
    set_idle(); ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd3; ld_rsp_data = 32'h55;
    cyc();
    chk("spur_err", 64'(err), 64'(1));
    chk("spur_addr", 64'(gpr_w_addr), 64'(3));
    chk("spur_data", 64'(gpr_w_data), 64'(32'h55));
    set_idle();
    cyc();

    // Asynchronous reset with loads pending and skid full
    ld_iss_vld = 1'b1; ld_iss_rd = 5'd13;
    cyc();
    ld_iss_rd = 5'd14;
    ld_rsp_vld = 1'b1; ld_rsp_rd = 5'd14; ld_rsp_data = 32'h44;
    alu_vld = 1'b1; alu_rd = 5'd16; alu_data = 32'h99;
    cyc();
    set_idle();
    #1 chk("pre_rst_alu_rdy", 64'(alu_rdy), 64'(0));
    #1 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 chk("midrst_rel_idle", 64'(idle), 64'(1));
    chk("midrst_rel_alu_rdy", 64'(alu_rdy), 64'(1));

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      alu_vld  = 1'($urandom_range(0, 1));
      alu_rd   = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      ld_iss_vld = ($urandom_range(0, 2) == 0);
      ld_iss_rd  = 5'($urandom_range(1, 7));
      plist.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) plist.push_back(5'(r));
      if (plist.size() != 0 && $urandom_range(0, 2) == 0) begin
        ld_rsp_vld  = 1'b1;
        ld_rsp_rd   = plist[$urandom_range(0, plist.size() - 1)];
        ld_rsp_data = $urandom;
      end
      hz_rs1 = 5'($urandom_range(0, 7));
      hz_rs2 = 5'($urandom_range(0, 7));
      hz_rd  = 5'($urandom_range(0, 7));
      cyc();
    end

    // Drain outstanding loads and check return to idle
    for (int k = 0; k < 20; k++) begin
      set_idle();
      for (int r = 1; r < 32; r++) begin
        if (m_pend[r] && !ld_rsp_vld) begin
          ld_rsp_vld = 1'b1; ld_rsp_rd = 5'(r); ld_rsp_data = $urandom;
        end
      end
      cyc();
    end
    set_idle();
    #1 chk("final_idle", 64'(idle), 64'(1));
    chk("final_err", 64'(err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
